// File: rtl/kernel_rd_addr_seq_pkg.sv
// Shared types and constants for the kernel read-address sequencer.
// Pure declarations: no latency, no flow control.
package kernel_seq_pkg;
   localparam int ADDR_W_DEF  = 12;
   localparam int DIM_W_DEF   = 7;
   localparam int DEPTH_W_DEF = 6;
   localparam int SPACE_W_DEF = 7;

   localparam logic MODE_1X1 = 1'b0;
   localparam logic MODE_3X3 = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONFIG,
      ST_PRESENT,
      ST_RUN,
      ST_DONE
   } seq_state_t;
endpackage

// File: rtl/kernel_rd_addr_seq_if.sv
// Control, window handshake and status bundle between a layer controller and the sequencer.
// slave = sequencer side, master = controller/consumer side; window held until win_ready_i.
interface kernel_rd_addr_seq_if
   import kernel_seq_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DIM_W   = DIM_W_DEF,
   parameter int DEPTH_W = DEPTH_W_DEF,
   parameter int SPACE_W = SPACE_W_DEF
) ();
   logic               start_i;
   logic               en_i;
   logic               ker_mode_i;
   logic [SPACE_W-1:0] addr_space_i;
   logic [DEPTH_W-1:0] ker_depth_i;
   logic [DIM_W-1:0]   layer_dim_i;
   logic               col_adv_i;
   logic               win_ready_i;
   logic               win_valid_o;
   logic [ADDR_W-1:0]  win_start_o;
   logic [ADDR_W-1:0]  win_end_o;
   logic               busy_o;
   logic               row_done_o;
   logic               layer_done_o;

   modport slave (
      input  start_i, en_i, ker_mode_i, addr_space_i, ker_depth_i, layer_dim_i,
      input  col_adv_i, win_ready_i,
      output win_valid_o, win_start_o, win_end_o, busy_o, row_done_o, layer_done_o
   );

   modport master (
      output start_i, en_i, ker_mode_i, addr_space_i, ker_depth_i, layer_dim_i,
      output col_adv_i, win_ready_i,
      input  win_valid_o, win_start_o, win_end_o, busy_o, row_done_o, layer_done_o
   );
endinterface

// File: rtl/kernel_rd_addr_seq_wrap_counter.sv
// Up-counter that returns to zero after reaching limit_i; wrap_o flags the wrapping increment.
// Count updates one cycle after inc_i; wrap_o is combinational; no flow control.
module wrap_counter #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   input  logic [W-1:0] limit_i,
   output logic         wrap_o
);
   logic [W-1:0] r_count;

   assign wrap_o = inc_i && (r_count == limit_i);

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_count <= '0;
      end else if (inc_i) begin
         r_count <= (r_count == limit_i) ? '0 : r_count + 1'b1;
      end
   end
endmodule

// File: rtl/kernel_rd_addr_seq.sv
// Walks kernel read windows column by column, kernel by kernel, row by row for one layer.
// First window 2 cycles after start_i; each window held until win_ready_i, col_adv_i counted only in RUN.
module kernel_rd_addr_seq
   import kernel_seq_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DIM_W   = DIM_W_DEF,
   parameter int DEPTH_W = DEPTH_W_DEF,
   parameter int SPACE_W = SPACE_W_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   kernel_rd_addr_seq_if.slave  bus
);
   seq_state_t         r_state;
   seq_state_t         w_next;
   logic               r_mode;
   logic [SPACE_W-1:0] r_space;
   logic [DEPTH_W-1:0] r_depth;
   logic [DIM_W-1:0]   r_dim;
   logic [ADDR_W-1:0]  r_f;
   logic [ADDR_W-1:0]  r_s;
   logic [ADDR_W-1:0]  w_space_ext;
   logic [ADDR_W-1:0]  w_f_calc;
   logic               w_col_inc;
   logic               w_col_wrap;
   logic               w_ker_wrap;
   logic               w_row_wrap;

   // A 3x3 kernel occupies nine 1x1 footprints: 8*space + space.
   assign w_space_ext = ADDR_W'(r_space);
   assign w_f_calc    = (r_mode == MODE_3X3) ? (w_space_ext << 3) + w_space_ext : w_space_ext;

   assign w_col_inc = (r_state == ST_RUN) && bus.col_adv_i && !bus.start_i;

   wrap_counter #(.W(DIM_W)) u_col_cnt (
      .clk_i(clk_i), .rst_i(rst_i), .clr_i(bus.start_i),
      .inc_i(w_col_inc), .limit_i(r_dim), .wrap_o(w_col_wrap)
   );

   wrap_counter #(.W(DEPTH_W)) u_ker_cnt (
      .clk_i(clk_i), .rst_i(rst_i), .clr_i(bus.start_i),
      .inc_i(w_col_wrap), .limit_i(r_depth), .wrap_o(w_ker_wrap)
   );

   wrap_counter #(.W(DIM_W)) u_row_cnt (
      .clk_i(clk_i), .rst_i(rst_i), .clr_i(bus.start_i),
      .inc_i(w_ker_wrap), .limit_i(r_dim), .wrap_o(w_row_wrap)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_mode  <= 1'b0;
         r_space <= '0;
         r_depth <= '0;
         r_dim   <= '0;
         r_f     <= '0;
         r_s     <= '0;
      end else begin
         r_state <= w_next;
         if (bus.start_i) begin
            r_mode  <= bus.ker_mode_i;
            r_space <= bus.addr_space_i;
            r_depth <= bus.ker_depth_i;
            r_dim   <= bus.layer_dim_i;
            r_s     <= '0;
         end else begin
            if (r_state == ST_CONFIG) begin
               r_f <= w_f_calc;
            end
            // Next kernel window follows directly; a new row restarts at address 0.
            if (w_col_wrap) begin
               r_s <= w_ker_wrap ? '0 : r_s + r_f;
            end
         end
      end
   end

   always_comb begin
      w_next           = r_state;
      bus.win_valid_o  = 1'b0;
      bus.win_start_o  = '0;
      bus.win_end_o    = '0;
      bus.busy_o       = (r_state != ST_IDLE);
      bus.row_done_o   = w_ker_wrap && !rst_i;
      bus.layer_done_o = (r_state == ST_DONE);

      if (bus.start_i) begin
         w_next = bus.en_i ? ST_CONFIG : ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    w_next = ST_IDLE;
            ST_CONFIG:  w_next = ST_PRESENT;
            ST_PRESENT: if (bus.win_ready_i) w_next = ST_RUN;
            ST_RUN: begin
               if (w_row_wrap)      w_next = ST_DONE;
               else if (w_col_wrap) w_next = ST_PRESENT;
            end
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
         endcase
      end

      if (r_state == ST_PRESENT) begin
         bus.win_valid_o = 1'b1;
         bus.win_start_o = r_s;
         bus.win_end_o   = r_s + r_f - 1'b1;
      end
   end
endmodule

// File: tb/tb_kernel_rd_addr_seq.sv
// Directed bench for kernel_rd_addr_seq: expected windows queued by stimulus, popped by a monitor.
// Done pulses are counted by the monitor and compared per scenario.
module tb_kernel_rd_addr_seq;
   import kernel_seq_pkg::*;

   localparam int AW = 12;
   localparam int DW = 7;
   localparam int KW = 6;
   localparam int SW = 7;

   typedef struct {
      int s;
      int e;
   } win_t;

   logic clk;
   logic rst;
   win_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   row_cnt = 0;
   int   layer_cnt = 0;
   int   acc_cnt = 0;
   logic prev_row = 1'b0;

   kernel_rd_addr_seq_if #(.ADDR_W(AW), .DIM_W(DW), .DEPTH_W(KW), .SPACE_W(SW)) bus ();

   kernel_rd_addr_seq #(.ADDR_W(AW), .DIM_W(DW), .DEPTH_W(KW), .SPACE_W(SW)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic push(input int s, input int e);
      win_t w;
      w.s = s;
      w.e = e;
      exp_q.push_back(w);
   endtask

   // Monitor: pops an expected window on every accepted presentation.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.row_done_o) row_cnt++;
         if (bus.layer_done_o) begin
            layer_cnt++;
            chk("layer_done_after_row_done", int'(prev_row), 1);
         end
         prev_row = bus.row_done_o;
         if (bus.win_valid_o && bus.win_ready_i) begin
            win_t w;
            acc_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_window actual_start=%0d actual_end=%0d", bus.win_start_o, bus.win_end_o);
            end else begin
               w = exp_q.pop_front();
               chk("win_start", int'(bus.win_start_o), w.s);
               chk("win_end", int'(bus.win_end_o), w.e);
            end
         end
      end
   end

   task automatic start_layer(input logic en, input logic mode, input int space, input int depth, input int dim);
      @(posedge clk); #1;
      bus.en_i         = en;
      bus.ker_mode_i   = mode;
      bus.addr_space_i = SW'(space);
      bus.ker_depth_i  = KW'(depth);
      bus.layer_dim_i  = DW'(dim);
      bus.start_i      = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      @(negedge clk);
      chk("busy_t1", int'(bus.busy_o), int'(en));
      chk("valid_t1", int'(bus.win_valid_o), 0);
      @(negedge clk);
      chk("valid_t2", int'(bus.win_valid_o), int'(en));
   endtask

   task automatic wait_layer(input int base_layer);
      int n;
      n = 0;
      while (layer_cnt <= base_layer && n < 400) begin
         @(posedge clk);
         n++;
      end
      chk("layer_done_seen", int'(layer_cnt > base_layer), 1);
      repeat (3) @(posedge clk);
   endtask

   int base_row, base_layer, base_acc, cnt, n;

   initial begin
      rst = 1'b1;
      bus.start_i = 1'b0; bus.en_i = 1'b0; bus.ker_mode_i = 1'b0;
      bus.addr_space_i = '0; bus.ker_depth_i = '0; bus.layer_dim_i = '0;
      bus.col_adv_i = 1'b0; bus.win_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(bus.busy_o), 0);
      chk("rst_valid", int'(bus.win_valid_o), 0);
      chk("rst_start", int'(bus.win_start_o), 0);
      chk("rst_end", int'(bus.win_end_o), 0);
      chk("rst_row_done", int'(bus.row_done_o), 0);
      chk("rst_layer_done", int'(bus.layer_done_o), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1x1, space 4, three kernels, 2x2 layer
      bus.win_ready_i = 1'b1; bus.col_adv_i = 1'b1;
      base_row = row_cnt; base_layer = layer_cnt;
      for (int r = 0; r < 2; r++) begin
         push(0, 3); push(4, 7); push(8, 11);
      end
      start_layer(1'b1, MODE_1X1, 4, 2, 1);
      wait_layer(base_layer);
      chk("s1_rows", row_cnt - base_row, 2);
      chk("s1_layers", layer_cnt - base_layer, 1);
      chk("s1_queue_empty", exp_q.size(), 0);
      chk("s1_idle", int'(bus.busy_o), 0);

      // 3x3, space 2, two kernels, single column/row
      base_row = row_cnt; base_layer = layer_cnt;
      push(0, 17); push(18, 35);
      start_layer(1'b1, MODE_3X3, 2, 1, 0);
      wait_layer(base_layer);
      chk("s2_rows", row_cnt - base_row, 1);
      chk("s2_layers", layer_cnt - base_layer, 1);
      chk("s2_queue_empty", exp_q.size(), 0);

      // 3x3, space 127: fourth window wraps the 12-bit address space
      base_row = row_cnt; base_layer = layer_cnt;
      push(0, 1142); push(1143, 2285); push(2286, 3428); push(3429, 475);
      start_layer(1'b1, MODE_3X3, 127, 3, 0);
      wait_layer(base_layer);
      chk("s3_rows", row_cnt - base_row, 1);
      chk("s3_queue_empty", exp_q.size(), 0);

      // Backpressure: window held while col_adv toggles; column count must not move
      bus.win_ready_i = 1'b0; bus.col_adv_i = 1'b0;
      base_row = row_cnt; base_layer = layer_cnt;
      push(0, 2); push(3, 5); push(0, 2); push(3, 5);
      start_layer(1'b1, MODE_1X1, 3, 1, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         bus.col_adv_i = ~bus.col_adv_i;
         @(negedge clk);
         chk("hold_valid", int'(bus.win_valid_o), 1);
         chk("hold_start", int'(bus.win_start_o), 0);
         chk("hold_end", int'(bus.win_end_o), 2);
      end
      @(posedge clk); #1;
      bus.win_ready_i = 1'b1; bus.col_adv_i = 1'b1;
      @(negedge clk);
      @(negedge clk); chk("hold_run_c1", int'(bus.win_valid_o), 0);
      @(negedge clk); chk("hold_run_c2", int'(bus.win_valid_o), 0);
      @(negedge clk); chk("hold_next_valid", int'(bus.win_valid_o), 1);
      chk("hold_next_start", int'(bus.win_start_o), 3);
      wait_layer(base_layer);
      chk("s4_rows", row_cnt - base_row, 2);
      chk("s4_queue_empty", exp_q.size(), 0);

      // Abort mid-RUN of row 1 with a new configuration
      base_row = row_cnt; base_layer = layer_cnt; base_acc = acc_cnt;
      push(0, 3); push(4, 7); push(0, 3); push(0, 4);
      start_layer(1'b1, MODE_1X1, 4, 1, 1);
      n = 0;
      while (acc_cnt < base_acc + 3 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("abort_reached_row1", int'(acc_cnt >= base_acc + 3), 1);
      chk("abort_layer_not_done", layer_cnt - base_layer, 0);
      start_layer(1'b1, MODE_1X1, 5, 0, 0);
      wait_layer(base_layer);
      chk("s5_rows", row_cnt - base_row, 2);
      chk("s5_layers", layer_cnt - base_layer, 1);
      chk("s5_queue_empty", exp_q.size(), 0);

      // Reset while presenting, then a disabled start
      bus.win_ready_i = 1'b0; bus.col_adv_i = 1'b0;
      base_row = row_cnt; base_layer = layer_cnt; base_acc = acc_cnt;
      start_layer(1'b1, MODE_3X3, 5, 0, 0);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", int'(bus.busy_o), 0);
      chk("mid_rst_valid", int'(bus.win_valid_o), 0);
      chk("mid_rst_start", int'(bus.win_start_o), 0);
      chk("mid_rst_end", int'(bus.win_end_o), 0);
      bus.win_ready_i = 1'b1; bus.col_adv_i = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1; bus.en_i = 1'b1; bus.start_i = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus.start_i = 1'b0;
      @(negedge clk);
      chk("rst_over_start_busy", int'(bus.busy_o), 0);
      start_layer(1'b0, MODE_1X1, 4, 2, 1);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.busy_o || bus.win_valid_o || bus.row_done_o || bus.layer_done_o) cnt++;
      end
      chk("disabled_quiet_cycles", cnt, 0);
      chk("s6_rows", row_cnt - base_row, 0);
      chk("s6_layers", layer_cnt - base_layer, 0);
      chk("s6_windows", acc_cnt - base_acc, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
